muldiv: RTL

Iterative multiply/divide unit in the execute stage, directly downstream of instruction decode. It consumes the decoded `op`, `regaData` and `regbData` and runs `mult`/`multu`/`div`/`divu` over 32 iterations. Results go into architectural HI/LO registers. While the operation runs, the unit asserts `stall` so that fetch, decode and the pipeline registers hold the instruction in place.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_if.sv | 22 ++
 rtl/muldiv.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: decoded opcodes,
// reset/valid constants, FSM state encoding and small arithmetic helpers.
package muldiv_pkg;

  localparam logic [5:0]  OP_NOP     = 6'h00;
  localparam logic [5:0]  OP_MULT    = 6'h18;
  localparam logic [5:0]  OP_MULTU   = 6'h19;
  localparam logic [5:0]  OP_DIV     = 6'h1a;
  localparam logic [5:0]  OP_DIVU    = 6'h1b;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic        VALID      = 1'b1;
  localparam logic        INVALID    = 1'b0;
  localparam logic [31:0] ZERO       = 32'd0;

  localparam logic [4:0]  LAST_ITER  = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the four opcodes this unit executes.
  function automatic logic is_muldiv(input logic [5:0] op);
    logic hit;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: hit = 1'b1;
      default:                           hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Two's complement negate when neg is set, pass-through otherwise.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (64'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage bus between decode/pipeline control and the mul/div unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic [5:0]  op;
  logic [31:0] rega_data;
  logic [31:0] regb_data;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op, rega_data, regb_data,
    input  stall, done, hi, lo
  );

  modport slave (
    input  op, rega_data, regb_data,
    output stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv.sv
// Iterative 32-iteration multiply (radix-2 shift-add) and restoring divide.
// Operands are taken as magnitudes; the sign fix-up is applied only when the
// final iteration writes HI/LO, so the datapath itself is purely unsigned.
module muldiv
  import muldiv_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  state_t       state_r, state_next_s;
  logic [4:0]   cnt_r;
  logic         is_div_r;
  logic         sign_a_r, sign_b_r;
  logic [31:0]  a_mag_r, b_mag_r;
  logic [31:0]  dividend_r;
  logic [63:0]  acc_r;        // mult: {partial product, multiplier}; div: low half is dividend/quotient
  logic [32:0]  rem_r;        // restoring-divide partial remainder
  logic [31:0]  hi_r, lo_r;
  logic         done_r;

  logic         start_s;
  logic         last_s;
  logic         start_sign_a_s, start_sign_b_s;
  logic [32:0]  mul_sum_s;
  logic [33:0]  rem_shift_s;
  logic [33:0]  diff_s;
  logic [32:0]  rem_next_s;
  logic [63:0]  acc_next_s;
  logic [63:0]  prod_s;
  logic [31:0]  res_hi_s, res_lo_s;

  assign start_s        = is_muldiv(bus.op);
  assign last_s         = (cnt_r == LAST_ITER);
  assign start_sign_a_s = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) && bus.rega_data[31];
  assign start_sign_b_s = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) && bus.regb_data[31];

  // State register.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and the stall request; stall is dropped whenever reset is high.
  always_comb begin
    state_next_s = state_r;
    bus.stall    = INVALID;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next_s = ST_BUSY;
          bus.stall    = (rst != RST_ENABLE);
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        bus.stall = (rst != RST_ENABLE);
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // One iteration of the shared datapath: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, a_mag_r} : 33'd0);
    rem_shift_s = {rem_r, acc_r[31]};
    diff_s      = rem_shift_s - {2'b00, b_mag_r};
    rem_next_s  = rem_r;
    acc_next_s  = acc_r;
    if (is_div_r) begin
      if (diff_s[33] == 1'b0) begin
        rem_next_s = diff_s[32:0];
        acc_next_s = {acc_r[63:32], acc_r[30:0], 1'b1};
      end else begin
        rem_next_s = rem_shift_s[32:0];
        acc_next_s = {acc_r[63:32], acc_r[30:0], 1'b0};
      end
    end else begin
      acc_next_s = {mul_sum_s, acc_r[31:1]};
    end
  end

  // Sign fix-up of the final iteration's result, including the divide-by-zero convention.
  always_comb begin
    prod_s   = cond_neg64(acc_next_s, sign_a_r ^ sign_b_r);
    res_hi_s = prod_s[63:32];
    res_lo_s = prod_s[31:0];
    if (is_div_r) begin
      if (b_mag_r == ZERO) begin
        res_hi_s = dividend_r;
        res_lo_s = 32'hffff_ffff;
      end else begin
        res_hi_s = cond_neg32(rem_next_s[31:0], sign_a_r);
        res_lo_s = cond_neg32(acc_next_s[31:0], sign_a_r ^ sign_b_r);
      end
    end else begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end
  end

  // Operand capture in IDLE, iteration in BUSY, HI/LO write and done pulse on the last iteration.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_r      <= 5'd0;
      is_div_r   <= 1'b0;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      a_mag_r    <= ZERO;
      b_mag_r    <= ZERO;
      dividend_r <= ZERO;
      acc_r      <= 64'd0;
      rem_r      <= 33'd0;
      hi_r       <= ZERO;
      lo_r       <= ZERO;
      done_r     <= INVALID;
    end else begin
      done_r <= INVALID;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            is_div_r   <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
            sign_a_r   <= start_sign_a_s;
            sign_b_r   <= start_sign_b_s;
            a_mag_r    <= cond_neg32(bus.rega_data, start_sign_a_s);
            b_mag_r    <= cond_neg32(bus.regb_data, start_sign_b_s);
            dividend_r <= bus.rega_data;
            cnt_r      <= 5'd0;
            rem_r      <= 33'd0;
            if ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) begin
              acc_r <= {32'd0, cond_neg32(bus.rega_data, start_sign_a_s)};
            end else begin
              acc_r <= {32'd0, cond_neg32(bus.regb_data, start_sign_b_s)};
            end
          end
        end
        ST_BUSY: begin
          acc_r <= acc_next_s;
          rem_r <= rem_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (last_s) begin
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
            done_r <= VALID;
          end
        end
        default: begin
          done_r <= INVALID;
        end
      endcase
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.done = done_r;

endmodule
